m_issue_ctrl: RTL

Core-side initiator for the M-extension/custom-modular coprocessor (`riscv_m_unit`). It accepts a decoded instruction with its operand values from the core's execute stage and checks that the unit owns it. It then issues the instruction with a one-cycle `valid` pulse and waits for `ready`. Finally it returns the result to the register-file write port over a valid/ready handshake, with timeout and illegal-instruction error reporting.

---
 rtl/m_issue_ctrl_pkg.sv | 43 ++++
 rtl/m_insn_decode.sv | 18 +
 rtl/m_issue_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/m_issue_ctrl_pkg.sv
// m_issue_ctrl_pkg: shared M-unit encodings plus issue-controller state and error types
package m_issue_ctrl_pkg;

    localparam logic [6:0] OPCODE        = 7'b0110011;
    localparam logic [6:0] OPCODE_CUSTOM = 7'b0001011;
    localparam logic [6:0] M_FUNCT7      = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } m_func3_t;

    typedef enum logic [2:0] {
        ADDMOD = 3'd0,
        SUBMOD = 3'd1,
        MODQ   = 3'd2
    } m_func3_custom_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_ERR
    } m_issue_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } m_issue_err_t;

    function automatic logic is_custom_func3(input logic [2:0] f3);
        return f3 == ADDMOD || f3 == SUBMOD || f3 == MODQ;
    endfunction

endpackage

// File: rtl/m_insn_decode.sv
// m_insn_decode: flags instructions owned by the M/custom-modular unit
module m_insn_decode
    import m_issue_ctrl_pkg::*;
(
    input  logic [31:0] insn,
    output logic        legal
);

    logic unused_bits;
    assign unused_bits = ^{insn[24:15], insn[11:7]};

    // funct7 must match; standard opcode takes any funct3, custom only the modular ops
    always_comb begin
        legal = insn[31:25] == M_FUNCT7 &&
                (insn[6:0] == OPCODE || (insn[6:0] == OPCODE_CUSTOM && is_custom_func3(insn[14:12])));
    end

endmodule

// File: rtl/m_issue_ctrl.sv
// m_issue_ctrl: issues decoded instructions to the M unit and returns results to writeback
module m_issue_ctrl
    import m_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        m_valid,
    output logic [31:0] m_instruction,
    output logic [31:0] m_rs1,
    output logic [31:0] m_rs2,
    input  logic        m_wr,
    input  logic [31:0] m_rd,
    input  logic        m_busy,
    input  logic        m_ready,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CW = $clog2(TIMEOUT);

    m_issue_state_t state, state_nx;
    m_issue_err_t   err_q;
    logic [CW-1:0]  cnt;
    logic           legal;
    logic           unused_busy;

    assign unused_busy = m_busy;
    assign wb_addr     = m_instruction[11:7];
    assign err_code    = err_q;

    m_insn_decode u_dec (
        .insn  (req_insn),
        .legal (legal)
    );

    // next state and state-decoded outputs; timeout fires as the counter steps onto TIMEOUT-1
    always_comb begin
        state_nx  = state;
        req_ready = state == ST_IDLE;
        busy      = state != ST_IDLE;
        m_valid   = state == ST_ISSUE;
        wb_valid  = state == ST_WB;
        err       = state == ST_ERR;
        case (state)
            ST_IDLE:  state_nx = req_valid ? (legal ? ST_ISSUE : ST_ERR) : ST_IDLE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  state_nx = m_ready ? ((m_wr && wb_addr != 5'd0) ? ST_WB : ST_IDLE)
                               : (cnt == CW'(TIMEOUT - 2) ? ST_ERR : ST_WAIT);
            ST_WB:    state_nx = wb_ready ? ST_IDLE : ST_WB;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // state, operand latches, timeout counter, result capture and sticky error code
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            err_q         <= ERR_NONE;
            m_instruction <= '0;
            m_rs1         <= '0;
            m_rs2         <= '0;
            wb_data       <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req_valid) begin
                m_instruction <= req_insn;
                m_rs1         <= req_rs1;
                m_rs2         <= req_rs2;
            end
            if (state == ST_ISSUE)
                cnt <= '0;
            else if (state == ST_WAIT && cnt != CW'(TIMEOUT - 1))
                cnt <= cnt + 1'b1;
            if (state == ST_WAIT && m_ready)
                wb_data <= m_rd;
            if (state_nx == ST_ERR)
                err_q <= state == ST_IDLE ? ERR_ILLEGAL : ERR_TIMEOUT;
        end
    end

endmodule
